miniscope_readout: RTL
======================

Name: miniscope_readout

Overview:
- Read-side sequencer for the miniscope FIFO RAM.
- On a readout request, drives the RAM read address (fifo_radr_mini) from a given start address for a programmed number of time bins.
- Presents each 16-bit RAM word to the DMB readout sequencer with a valid/ready handshake at full throughput, and accumulates RAM parity errors.
- Sits between the miniscope storage block and the DMB data-stream builder.

Parameters:
- RAM_ADRB, 11, RAM address width; addresses wrap modulo 2**RAM_ADRB.
- RAM_WIDTH, 8, width of one RAM bank; the read word is 2*RAM_WIDTH bits.
- TBIN_BITS, 5, width of the time-bin count.

Ports:
- clock  in  1  TMB 40 MHz main clock.
- reset_n  in  1  asynchronous active-low reset.
- rd_start  in  1  one-cycle readout request; sampled only in IDLE.
- rd_adr_start  in  RAM_ADRB  RAM address of the first time bin.
- rd_ntbins  in  TBIN_BITS  number of time bins to read; 0 = none.
- fifo_radr_mini  out  RAM_ADRB  RAM port-B read address.
- fifo_rdata_mini  in  2*RAM_WIDTH  RAM port-B read data, valid 1 clock after address.
- parity_err_mini  in  2  per-bank parity error, aligned with fifo_rdata_mini.
- mini_rd_data  out  2*RAM_WIDTH  word to DMB stream.
- mini_rd_valid  out  1  mini_rd_data is valid.
- mini_rd_last  out  1  current word is the final time bin.
- mini_rd_ready  in  1  consumer accepts the word this cycle.
- rd_busy  out  1  readout in progress (PRIME or SEND).
- rd_done  out  1  one-cycle pulse when readout completes.
- perr_clear  in  1  clears the sticky parity flags.
- parity_err_sticky  out  2  per-bank sticky parity error.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; rd_adr=0; cnt=0. All outputs 0: fifo_radr_mini, mini_rd_valid, mini_rd_last, rd_busy, rd_done, parity_err_sticky.
- Reset asserted mid-readout aborts immediately: valid drops and no rd_done is issued.
- fire = mini_rd_valid & mini_rd_ready.
- Address output (combinational):
  - PRIME: fifo_radr_mini = rd_adr.
  - SEND: fifo_radr_mini = fire ? rd_adr+1 : rd_adr. This lookahead makes the next word appear the cycle after acceptance, giving one word per clock with ready held high.
  - IDLE: fifo_radr_mini = rd_adr.
- All address arithmetic wraps modulo 2**RAM_ADRB (0x7FF+1 = 0x000).
- mini_rd_data = fifo_rdata_mini (pass-through of the registered RAM output). It is held stable during stall because the address is held.
- State machine:
  - IDLE: rd_busy=0.
    - On rd_start with rd_ntbins != 0: rd_adr <= rd_adr_start; cnt <= rd_ntbins-1; go to PRIME.
    - On rd_start with rd_ntbins == 0: pulse rd_done on the next cycle; no words; stay in IDLE.
  - PRIME (1 cycle): rd_busy=1, valid=0. The RAM latches rd_adr. Go to SEND.
  - SEND: rd_busy=1, mini_rd_valid=1, mini_rd_last=(cnt==0).
    - On fire with cnt != 0: rd_adr <= rd_adr+1; cnt <= cnt-1.
    - On fire with cnt == 0: go to IDLE; rd_done=1 for the following cycle.
    - With ready low: hold everything.
- rd_start outside IDLE is ignored. rd_adr_start and rd_ntbins are sampled only with an accepted rd_start.
- Latency: rd_start at cycle N -> PRIME at N+1 -> first valid word at N+2. An n-word readout with ready=1 finishes its last fire at N+1+n, with rd_done at N+2+n.
- Parity:
  - On each fire, parity_err_sticky <= parity_err_sticky | parity_err_mini.
  - perr_clear zeroes both flags. If clear and set occur in the same cycle, set wins for the erroring bank.
  - Parity is ignored when not firing.
- Maximum count is 2**TBIN_BITS-1 = 31 words.

Test Plan:
1. Basic readout: RAM in data=address test mode, rd_adr_start=0x010, rd_ntbins=4, ready=1 -> first word at N+2; words 0x0010, 0x0011, 0x0012, 0x0013 on consecutive cycles; last only on 0x0013; rd_done at N+6; rd_busy high for cycles N+1..N+5.
2. Wrap: rd_adr_start=0x7FE, rd_ntbins=4 -> words 0x07FE, 0x07FF, 0x0000, 0x0001 with fifo_radr_mini wrapping to 0x000.
3. Backpressure: rd_adr_start=0x100, n=3, ready pattern 1,0,0,1,0,1 -> data holds 0x0101 through the stall; each word is delivered exactly once, in order; no duplicates; rd_done after the third fire.
4. Zero/ignored starts:
   - rd_ntbins=0 -> rd_done 1 cycle later; no valid; rd_busy stays 0.
   - rd_start during SEND -> ignored; word count unchanged.
5. Parity:
   - Force parity_err_mini=2'b10 on the 2nd fired word -> parity_err_sticky=2'b10 from the next cycle; unchanged by error pulses on non-fire cycles.
   - Assert perr_clear with parity_err_mini=2'b01 on a fire -> 2'b01.
6. Reset mid-readout: assert reset_n=0 during word 2 of 5 -> valid, busy, last and sticky go to 0 asynchronously; no rd_done; a new rd_start after release restarts cleanly.

Source files
------------

// File: rtl/miniscope_readout_if.sv
// Purpose : bundles the miniscope read-side signals: RAM port-B, DMB stream handshake, status, parity.
// Ports   : master = readout sequencer side; slave = RAM / DMB consumer / control side.
// Clocking: carries no clock or reset; those stay plain ports on the sequencer.
interface miniscope_readout_if #(
   parameter int RAM_ADRB  = 11,
   parameter int RAM_WIDTH = 8,
   parameter int TBIN_BITS = 5
);
   logic                   rd_start;
   logic [RAM_ADRB-1:0]    rd_adr_start;
   logic [TBIN_BITS-1:0]   rd_ntbins;
   logic [RAM_ADRB-1:0]    fifo_radr_mini;
   logic [2*RAM_WIDTH-1:0] fifo_rdata_mini;
   logic [1:0]             parity_err_mini;
   logic [2*RAM_WIDTH-1:0] mini_rd_data;
   logic                   mini_rd_valid;
   logic                   mini_rd_last;
   logic                   mini_rd_ready;
   logic                   rd_busy;
   logic                   rd_done;
   logic                   perr_clear;
   logic [1:0]             parity_err_sticky;

   modport master (
      input  rd_start, rd_adr_start, rd_ntbins, fifo_rdata_mini, parity_err_mini,
             mini_rd_ready, perr_clear,
      output fifo_radr_mini, mini_rd_data, mini_rd_valid, mini_rd_last,
             rd_busy, rd_done, parity_err_sticky
   );

   modport slave (
      output rd_start, rd_adr_start, rd_ntbins, fifo_rdata_mini, parity_err_mini,
             mini_rd_ready, perr_clear,
      input  fifo_radr_mini, mini_rd_data, mini_rd_valid, mini_rd_last,
             rd_busy, rd_done, parity_err_sticky
   );
endinterface

// File: rtl/miniscope_readout.sv
// Purpose : reads rd_ntbins words from the miniscope FIFO RAM starting at rd_adr_start, streams them out.
// Latency : rd_start at N -> PRIME at N+1 -> first word at N+2; one word/clock with ready high; rd_done the cycle after the last fire.
// Backpressure: ready low holds state, address and data; parity only accumulates on accepted words.
// Ports   : clock, reset_n (async active-low), bus (miniscope_readout_if.master: request, RAM port-B, stream, status, parity).
module miniscope_readout #(
   parameter int RAM_ADRB  = 11,
   parameter int RAM_WIDTH = 8,
   parameter int TBIN_BITS = 5
) (
   input  logic                 clock,
   input  logic                 reset_n,
   miniscope_readout_if.master  bus
);
   typedef enum logic [1:0] {IDLE, PRIME, SEND} state_t;

   localparam logic [RAM_ADRB-1:0]  ADR_ONE = RAM_ADRB'(1);
   localparam logic [TBIN_BITS-1:0] CNT_ONE = TBIN_BITS'(1);

   state_t                 state_q;
   logic [RAM_ADRB-1:0]    rd_adr_q;
   logic [TBIN_BITS-1:0]   cnt_q;
   logic                   valid_q;
   logic                   last_q;
   logic                   busy_q;
   logic                   done_q;
   logic [1:0]             sticky_q;
   logic [1:0]             sticky_d;
   logic [RAM_ADRB-1:0]    rd_adr_inc;
   logic [2*RAM_WIDTH-1:0] rdata;
   logic                   fire;

   assign fire       = valid_q & bus.mini_rd_ready;
   assign rd_adr_inc = rd_adr_q + ADR_ONE;

   // Present the next address as soon as the current word is accepted so the
   // RAM output already holds the following word in the next cycle.
   assign bus.fifo_radr_mini = (state_q == SEND && fire) ? rd_adr_inc : rd_adr_q;

   // RAM output is registered and the address is held on stall, so the data is stable.
   assign rdata              = bus.fifo_rdata_mini;
   assign bus.mini_rd_data   = rdata;
   assign bus.mini_rd_valid  = valid_q;
   assign bus.mini_rd_last   = last_q;
   assign bus.rd_busy        = busy_q;
   assign bus.rd_done        = done_q;
   assign bus.parity_err_sticky = sticky_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         rd_adr_q <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.rd_start) begin
                  if (bus.rd_ntbins != '0) begin
                     rd_adr_q <= bus.rd_adr_start;
                     cnt_q    <= bus.rd_ntbins - CNT_ONE;
                     busy_q   <= 1'b1;
                     state_q  <= PRIME;
                  end else begin
                     done_q   <= 1'b1;
                  end
               end
            end
            PRIME: begin
               // RAM latches rd_adr this cycle; its word is presented next cycle.
               valid_q <= 1'b1;
               last_q  <= (cnt_q == '0);
               state_q <= SEND;
            end
            SEND: begin
               if (fire) begin
                  if (cnt_q != '0) begin
                     rd_adr_q <= rd_adr_inc;
                     cnt_q    <= cnt_q - CNT_ONE;
                     last_q   <= (cnt_q == CNT_ONE);
                  end else begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Clear first, then OR in the new error, so a bank erroring on the
   // clearing cycle stays flagged.
   always_comb begin
      sticky_d = sticky_q;
      if (bus.perr_clear) sticky_d = 2'b00;
      if (fire)           sticky_d = sticky_d | bus.parity_err_mini;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) sticky_q <= 2'b00;
      else          sticky_q <= sticky_d;
   end
endmodule
